// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver feeding a WIDTH-bit
// parallel load register.
//
// Frame on the wire (one bit per bit_en strobe, line idles high):
//   start(0) | WIDTH data bits | [even parity] | stop(1)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - async active-low reset (deassertion synchronized inside)
//   bit_en     - sample strobe; sin is consumed only when bit_en=1
//   sin        - serial data in
//   pout       - last good word (held across bad frames)
//   load       - one-cycle pulse, pout carries a freshly received word
//   parity_err - one-cycle pulse, frame dropped on bad even parity
//   frame_err  - one-cycle pulse, frame dropped on stop bit = 0
//   busy       - frame in progress (state != IDLE)
//
// WIDTH must be >= 2.
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             load,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  // Reset synchronizer: assertion passes straight through the async clear,
  // release reaches the rest of the block two edges after rst_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             load_q, load_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    pout_d  = pout_q;
    // Status strobes drop every cycle, so they stay one cycle wide even
    // when bit_en is held high or the next strobe is far away.
    load_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = '0;
            sr_d    = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          // LSB-first: bits enter at the top and walk down, so the first
          // bit lands in [0] after WIDTH shifts. MSB-first is the mirror.
          if (LSB_FIRST) sr_d = {sin, sr_q[WIDTH-1:1]};
          else           sr_d = {sr_q[WIDTH-2:0], sin};
          par_d = par_q ^ sin;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          // Folding the parity bit in leaves par=0 for a good even frame.
          par_d   = par_q ^ sin;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A broken stop bit outranks a parity problem.
          if (!sin) begin
            ferr_d = 1'b1;
          end else if (PARITY_EN && par_q) begin
            perr_d = 1'b1;
          end else begin
            pout_d = sr_q;
            load_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      pout_q  <= '0;
      load_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      pout_q  <= pout_d;
      load_q  <= load_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign pout       = pout_q;
  assign load       = load_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: dut1 uses defaults, dut2 runs with
// PARITY_EN=0, LSB_FIRST=0.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       be1 = 1'b0, s1 = 1'b1, be2 = 1'b0, s2 = 1'b1;
  logic [3:0] pout1, pout2;
  logic       load1, perr1, ferr1, busy1;
  logic       load2, perr2, ferr2, busy2;

  always #5 clk = ~clk;

  sipo_frame_rx u_dut1 (
    .clk(clk), .rst_n(rst_n), .bit_en(be1), .sin(s1),
    .pout(pout1), .load(load1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1'b0), .LSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bit_en(be2), .sin(s2),
    .pout(pout2), .load(load2), .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
  );

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int nload1 = 0, nperr1 = 0, nferr1 = 0, nbusy1 = 0, nmulti = 0;
  int nload2 = 0, nperr2 = 0, nferr2 = 0;
  int lcyc_last = 0, lcyc_prev = 0;
  int l0, p0, f0, b0, l2, p2, f2;
  logic [3:0] dreg = 4'h0;

  // downstream load register model
  always @(posedge clk) begin
    cyc++;
    if (load1) dreg <= pout1;
  end

  always @(negedge clk) begin
    if (load1) begin nload1++; lcyc_prev = lcyc_last; lcyc_last = cyc; end
    if (perr1) nperr1++;
    if (ferr1) nferr1++;
    if (busy1) nbusy1++;
    if (int'(load1) + int'(perr1) + int'(ferr1) > 1) nmulti++;
    if (load2) nload2++;
    if (perr2) nperr2++;
    if (ferr2) nferr2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    l0 = nload1; p0 = nperr1; f0 = nferr1; b0 = nbusy1;
    l2 = nload2; p2 = nperr2; f2 = nferr2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      be1 = 1'b0; s1 = 1'b1; be2 = 1'b0; s2 = 1'b1;
    end
    #1;
  endtask

  // bits[0] goes out first; gap idle cycles (sin toggling) before each strobe
  task automatic send_bits(input int which, input logic [7:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        @(negedge clk);
        if (which == 1) begin be1 = 1'b0; s1 = ~s1; end
        else            begin be2 = 1'b0; s2 = ~s2; end
      end
      @(negedge clk);
      if (which == 1) begin be1 = 1'b1; s1 = bits[i]; end
      else            begin be2 = 1'b1; s2 = bits[i]; end
    end
  endtask

  task automatic run1(input string tag, input logic [3:0] d, input logic p, input logic s,
                      input int gap, input int el, input int ep, input int ef,
                      input logic [3:0] epout);
    snap();
    send_bits(1, {1'b0, s, p, d, 1'b0}, 7, gap);
    idle(1);
    chk({tag, "_pulse_at_stop"}, {load1, perr1, ferr1}, {el[0], ep[0], ef[0]});
    idle(3);
    chk({tag, "_nload"}, nload1 - l0, el);
    chk({tag, "_nperr"}, nperr1 - p0, ep);
    chk({tag, "_nferr"}, nferr1 - f0, ef);
    chk({tag, "_pout"}, pout1, epout);
    chk({tag, "_busy_idle"}, busy1, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out1", {pout1, load1, perr1, ferr1, busy1}, 0);
    chk("rst_out2", {pout2, load2, perr2, ferr2, busy2}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // A = 1010, LSB-first 0,1,0,1, two ones -> parity 0
    run1("goodA", 4'hA, 1'b0, 1'b1, 0, 1, 0, 0, 4'hA);
    // D = 1101 needs parity 1; send 0
    run1("perrD", 4'hD, 1'b0, 1'b1, 0, 0, 1, 0, 4'hA);
    run1("goodD", 4'hD, 1'b1, 1'b1, 0, 1, 0, 0, 4'hD);
    chk("goodD_busy_cycles", nbusy1 - b0, 6);
    run1("ferr_goodpar", 4'h6, 1'b0, 1'b0, 0, 0, 0, 1, 4'hD);
    run1("ferr_badpar", 4'h6, 1'b1, 1'b0, 0, 0, 0, 1, 4'hD);
    // 3 = 0011, two ones -> parity 0; strobe every 3rd cycle
    run1("stretch3", 4'h3, 1'b0, 1'b1, 2, 1, 0, 0, 4'h3);

    // reset after start + 2 data bits of A
    snap();
    send_bits(1, 8'h54, 3, 0);
    @(posedge clk); #2;
    chk("midrst_busy_before", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {pout1, load1, perr1, ferr1, busy1}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("midrst_no_pulse", (nload1 - l0) + (nperr1 - p0) + (nferr1 - f0), 0);
    run1("postrst_A", 4'hA, 1'b0, 1'b1, 0, 1, 0, 0, 4'hA);

    // back-to-back: 1 (parity 1) then F (parity 0), no idle strobe between
    snap();
    send_bits(1, {1'b0, 1'b1, 1'b1, 4'h1, 1'b0}, 7, 0);
    send_bits(1, {1'b0, 1'b1, 1'b0, 4'hF, 1'b0}, 7, 0);
    idle(4);
    chk("b2b_nload", nload1 - l0, 2);
    chk("b2b_spacing", lcyc_last - lcyc_prev, 7);
    chk("b2b_pout", pout1, 4'hF);
    chk("b2b_dreg", dreg, 4'hF);
    chk("b2b_errs", (nperr1 - p0) + (nferr1 - f0), 0);
    chk("exclusive_pulses", nmulti, 0);

    // dut2: serial 0 | 1,0,0,0 | 1 -> MSB-first 4'h8 after 6 strobes
    snap();
    send_bits(2, 8'h22, 6, 0);
    idle(1);
    chk("d2_load_at_stop", load2, 1);
    chk("d2_pout8", pout2, 4'h8);
    idle(2);
    chk("d2_nload", nload2 - l2, 1);
    // odd-weight data 1,1,1,0 -> 4'hE; no parity bit so it must load
    snap();
    send_bits(2, 8'h2E, 6, 0);
    idle(3);
    chk("d2_poutE", pout2, 4'hE);
    chk("d2_nload_E", nload2 - l2, 1);
    // stop = 0
    snap();
    send_bits(2, 8'h1E, 6, 0);
    idle(3);
    chk("d2_ferr", nferr2 - f2, 1);
    chk("d2_ferr_nload", nload2 - l2, 0);
    chk("d2_pout_held", pout2, 4'hE);
    chk("d2_no_perr", nperr2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
